// File: rtl/des_core_arbiter.sv
// -----------------------------------------------------------------------------
// des_core_arbiter
//
// Shares a single DES core (ap_ctrl_hs handshake) among NUM_REQ requesters.
// A round-robin arbiter picks one requester while the core reports idle and
// latches its data word. The arbiter then runs the core's start/done handshake
// and captures the 64-bit result. The result is returned to the same requester
// over a one-hot valid/ready response channel. Only one job is in flight at a
// time.
//
// Optional feature macro: DES_ARB_WDOG_EN
//   When defined, a watchdog counter aborts a job after WDOG_CYCLES cycles in
//   START/WAIT without core_ap_done. The job is answered with resp_err=1 and
//   resp_data=0.
//   When undefined, resp_err is tied low and a hung core stalls the arbiter.
//
// Ports:
//   ap_clk, ap_rst    clock, synchronous active-high reset
//   req_valid/ready   per-requester job request / one-hot acceptance pulse
//   req_data          packed request words, requester i owns slice i
//   resp_valid/ready  one-hot response valid / per-requester accept
//   resp_data         captured core result (zero on watchdog abort)
//   resp_err          job aborted, qualified by resp_valid
//   busy              job in flight (any state other than IDLE)
//   grant_id          index of the current or last granted requester
//   core_*            ap_ctrl_hs handshake, input data and result of the core
// -----------------------------------------------------------------------------
module des_core_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DIN_W       = 32,
  parameter int DOUT_W      = 64,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*DIN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [DOUT_W-1:0]        resp_data,
  output logic                     resp_err,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic                     core_ap_start,
  input  logic                     core_ap_done,
  input  logic                     core_ap_idle,
  input  logic                     core_ap_ready,
  output logic [DIN_W-1:0]         core_inputdata,
  input  logic [DOUT_W-1:0]        core_result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [DIN_W-1:0]  data_q, data_d;
  logic [DOUT_W-1:0] result_q, result_d;

  logic [ID_W-1:0]   pick_s;
  logic              found_s;
  logic              grant_s;
  logic              abort_s;
  logic [DIN_W-1:0]  req_slice_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign req_slice_s[i] = req_data[i*DIN_W +: DIN_W];
  end

  // Round-robin search: first asserted request after last_grant, wrapping.
  always_comb begin
    logic [ID_W-1:0] cand;
    logic            hit;
    pick_s  = '0;
    found_s = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand    = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      hit     = !found_s && req_valid[cand];
      pick_s  = hit ? cand : pick_s;
      found_s = found_s | hit;
    end
  end

  // A grant never fires while reset is applied, so no requester sees an
  // acceptance for a job that reset is about to discard.
  assign grant_s = (state_q == ST_IDLE) && core_ap_idle && found_s && !ap_rst;

`ifdef DES_ARB_WDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);

  logic [31:0] wdog_cnt_q, wdog_cnt_d;
  logic        err_q, err_d;
  logic        wdog_expire_s;

  assign wdog_expire_s = (wdog_cnt_q == WDOG_LAST);

  // Expiry aborts only when the core has not completed in the same cycle.
  assign abort_s = wdog_expire_s &&
                   (((state_q == ST_START) && !(core_ap_ready && core_ap_done)) ||
                    ((state_q == ST_WAIT) && !core_ap_done));

  // Watchdog count: held at zero in IDLE so it starts at zero on entering START.
  always_comb begin
    if (state_q == ST_IDLE) begin
      wdog_cnt_d = 32'd0;
    end else if ((state_q == ST_START) || (state_q == ST_WAIT)) begin
      wdog_cnt_d = wdog_cnt_q + 32'd1;
    end else begin
      wdog_cnt_d = wdog_cnt_q;
    end
  end

  // Abort flag: set when a job is abandoned, cleared at the next grant.
  always_comb begin
    if (abort_s) begin
      err_d = 1'b1;
    end else if (grant_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wdog_cnt_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      err_q      <= err_d;
    end
  end
`else
  logic unused_wdog_s;

  assign abort_s       = 1'b0;
  assign unused_wdog_s = (WDOG_CYCLES > 0);
`endif

  // State and datapath registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      data_q       <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      data_q       <= data_d;
      result_q     <= result_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    data_d       = data_q;
    result_d     = result_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d    = ST_START;
          grant_id_d = pick_s;
          data_d     = req_slice_s[pick_s];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (core_ap_ready && core_ap_done) begin
          state_d  = ST_RESP;
          result_d = core_result;
        end else if (abort_s) begin
          state_d  = ST_RESP;
          result_d = '0;
        end else if (core_ap_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_START;
        end
      end
      ST_WAIT: begin
        if (core_ap_done) begin
          state_d  = ST_RESP;
          result_d = core_result;
        end else if (abort_s) begin
          state_d  = ST_RESP;
          result_d = '0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        // Only the granted requester's accept closes the job.
        if (resp_ready[grant_id_q]) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_id_q;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready     = '0;
    resp_valid    = '0;
    core_ap_start = 1'b0;
    busy          = 1'b0;
    resp_err      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready[pick_s] = grant_s;
      end
      ST_START: begin
        core_ap_start = 1'b1;
        busy          = 1'b1;
      end
      ST_WAIT: begin
        busy = 1'b1;
      end
      ST_RESP: begin
        busy                   = 1'b1;
        resp_valid[grant_id_q] = 1'b1;
`ifdef DES_ARB_WDOG_EN
        resp_err = err_q;
`else
        resp_err = 1'b0;
`endif
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign resp_data      = result_q;
  assign grant_id       = grant_id_q;
  assign core_inputdata = data_q;

endmodule

// File: tb/tb_des_core_arbiter.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for des_core_arbiter. The bench plays the DES
// core by driving the ap_ctrl_hs inputs by hand. Inputs change just after the
// falling edge, and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_des_core_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DIN_W   = 32;
  localparam int DOUT_W  = 64;
  localparam int WDOG_N  = 16;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*DIN_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [DOUT_W-1:0]        resp_data;
  logic                     resp_err;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;
  logic                     core_ap_start;
  logic                     core_ap_done;
  logic                     core_ap_idle;
  logic                     core_ap_ready;
  logic [DIN_W-1:0]         core_inputdata;
  logic [DOUT_W-1:0]        core_result;

  int n_vec = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  des_core_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIN_W(DIN_W), .DOUT_W(DOUT_W),
    .WDOG_CYCLES(WDOG_N)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .grant_id(grant_id),
    .core_ap_start(core_ap_start), .core_ap_done(core_ap_done),
    .core_ap_idle(core_ap_idle), .core_ap_ready(core_ap_ready),
    .core_inputdata(core_inputdata), .core_result(core_result)
  );

  function automatic logic [31:0] slice_val(input int i);
    return 32'h1111_0000 + 32'(i);
  endfunction

  function automatic logic [63:0] res_val(input int i);
    return {32'hDE5C_0000 + 32'(i), 32'hFFFF_FFFF ^ slice_val(i)};
  endfunction

  task automatic load_slices();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DIN_W +: DIN_W] = slice_val(i);
  endtask

  task automatic do_reset();
    ap_rst = 1'b1; req_valid = '0; resp_ready = '0;
    core_ap_done = 1'b0; core_ap_ready = 1'b0; core_ap_idle = 1'b1;
    core_result = '0;
    repeat (2) @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  // Called in the first START cycle: ready+done together, then accept.
  task automatic serve_from_start(input int id, input logic [63:0] res);
    core_ap_ready = 1'b1; core_ap_done = 1'b1; core_result = res;
    @(negedge ap_clk);
    core_ap_ready = 1'b0; core_ap_done = 1'b0; core_result = '0;
    resp_ready = 4'b0001 << id;
    @(negedge ap_clk);
    resp_ready = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if ({busy, resp_valid, req_ready, core_ap_start, resp_err} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 0", {busy, resp_valid, req_ready, core_ap_start, resp_err});
    end
    n_vec++;
    if ({grant_id, resp_data, core_inputdata} !== 98'd0) begin
      n_err++;
      $display("FAIL reset_data got %h/%h/%h want 0", grant_id, resp_data, core_inputdata);
    end
  endtask

  task automatic test_single_job();
    req_data[31:0] = 32'h0123_4567;
    req_valid = 4'b0001;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL sj_req_ready got %b want 0001", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    n_vec++;
    if (req_ready !== 4'b0000) begin n_err++; $display("FAIL sj_ready_pulse got %b want 0000", req_ready); end
    n_vec++;
    if (core_ap_start !== 1'b1 || core_inputdata !== 32'h0123_4567 || grant_id !== 2'd0) begin
      n_err++;
      $display("FAIL sj_start got %b/%h/%0d want 1/01234567/0", core_ap_start, core_inputdata, grant_id);
    end
    @(negedge ap_clk);
    #1;
    n_vec++;
    if (core_ap_start !== 1'b1) begin n_err++; $display("FAIL sj_start_hold got %b want 1", core_ap_start); end
    core_ap_ready = 1'b1;
    @(negedge ap_clk);
    core_ap_ready = 1'b0;
    #1;
    n_vec++;
    if (core_ap_start !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL sj_wait got start=%b busy=%b want 0/1", core_ap_start, busy);
    end
    repeat (3) @(negedge ap_clk);
    core_ap_done = 1'b1; core_result = 64'h85E8_1354_0F0A_B405;
    @(negedge ap_clk);
    core_ap_done = 1'b0; core_result = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++;
      if (resp_valid !== 4'b0001 || resp_data !== 64'h85E8_1354_0F0A_B405 || resp_err !== 1'b0) begin
        n_err++;
        $display("FAIL sj_resp c%0d got %b/%h/%b want 0001/85e813540f0ab405/0", c, resp_valid, resp_data, resp_err);
      end
      @(negedge ap_clk);
    end
    resp_ready = 4'b0001;
    @(negedge ap_clk);
    resp_ready = '0;
    #1;
    n_vec++;
    if (resp_valid !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL sj_done got %b/%b want 0000/0", resp_valid, busy);
    end
    load_slices();
  endtask

  task automatic test_round_robin();
    int exp;
    do_reset();
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp = j % NUM_REQ;
      #1;
      n_vec++;
      if (req_ready !== (4'b0001 << exp)) begin
        n_err++; $display("FAIL rr_grant j%0d got %b want %b", j, req_ready, 4'b0001 << exp);
      end
      @(negedge ap_clk);
      #1;
      n_vec++;
      if (grant_id !== ID_W'(exp) || core_inputdata !== slice_val(exp)) begin
        n_err++; $display("FAIL rr_start j%0d got %0d/%h want %0d/%h", j, grant_id, core_inputdata, exp, slice_val(exp));
      end
      core_ap_ready = 1'b1; core_ap_done = 1'b1; core_result = res_val(exp);
      @(negedge ap_clk);
      core_ap_ready = 1'b0; core_ap_done = 1'b0; core_result = '0;
      #1;
      n_vec++;
      if (resp_valid !== (4'b0001 << exp) || resp_data !== res_val(exp)) begin
        n_err++; $display("FAIL rr_resp j%0d got %b/%h want %b/%h", j, resp_valid, resp_data, 4'b0001 << exp, res_val(exp));
      end
      resp_ready = 4'b0001 << exp;
      @(negedge ap_clk);
      resp_ready = '0;
    end
    req_valid = 4'b0010;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rr_to1 got %b want 0010", req_ready); end
    @(negedge ap_clk);
    req_valid = 4'b1001;
    serve_from_start(1, res_val(1));
    #1;
    n_vec++;
    if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rr_wrap3 got %b want 1000", req_ready); end
    @(negedge ap_clk);
    serve_from_start(3, res_val(3));
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rr_wrap0 got %b want 0001", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    serve_from_start(0, res_val(0));
  endtask

  task automatic test_core_busy();
    core_ap_idle = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_vec++;
      if (req_ready !== 4'b0000 || busy !== 1'b0) begin
        n_err++; $display("FAIL cb_hold c%0d got %b/%b want 0000/0", c, req_ready, busy);
      end
      @(negedge ap_clk);
    end
    core_ap_idle = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 4'b0010) begin n_err++; $display("FAIL cb_grant got %b want 0010", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    n_vec++;
    if (grant_id !== 2'd1 || busy !== 1'b1) begin
      n_err++; $display("FAIL cb_start got %0d/%b want 1/1", grant_id, busy);
    end
    serve_from_start(1, res_val(1));
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0100;
    #1;
    n_vec++;
    if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_grant got %b want 0100", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    core_ap_ready = 1'b1; core_ap_done = 1'b1; core_result = 64'hCAFE_F00D_1234_5678;
    @(negedge ap_clk);
    core_ap_ready = 1'b0; core_ap_done = 1'b0; core_result = '0;
    req_valid = 4'b0001;
    resp_ready = 4'b1011;
    for (int c = 0; c < 20; c++) begin
      #1;
      n_vec++;
      if (resp_valid !== 4'b0100 || resp_data !== 64'hCAFE_F00D_1234_5678 || req_ready !== 4'b0000) begin
        n_err++; $display("FAIL bp_stall c%0d got %b/%h/%b want 0100/cafef00d12345678/0000", c, resp_valid, resp_data, req_ready);
      end
      @(negedge ap_clk);
    end
    resp_ready = 4'b0100;
    @(negedge ap_clk);
    resp_ready = '0;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_next got %b want 0001", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    serve_from_start(0, res_val(0));
  endtask

  task automatic test_reset_mid_job();
    req_valid = 4'b0100;
    @(negedge ap_clk);
    req_valid = '0;
    core_ap_ready = 1'b1;
    @(negedge ap_clk);
    core_ap_ready = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b1 || core_ap_start !== 1'b0 || grant_id !== 2'd2) begin
      n_err++; $display("FAIL rst_wait got %b/%b/%0d want 1/0/2", busy, core_ap_start, grant_id);
    end
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || core_ap_start !== 1'b0 || resp_valid !== 4'b0000 || grant_id !== 2'd0 || core_inputdata !== 32'd0) begin
      n_err++; $display("FAIL rst_mid got %b/%b/%b/%0d/%h want 0/0/0000/0/0", busy, core_ap_start, resp_valid, grant_id, core_inputdata);
    end
    req_valid = 4'b1111;
    #1;
    n_vec++;
    if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_next got %b want 0001", req_ready); end
    @(negedge ap_clk);
    req_valid = '0;
    serve_from_start(0, res_val(0));
    core_ap_done = 1'b1; core_result = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge ap_clk);
    core_ap_done = 1'b0; core_result = '0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || resp_valid !== 4'b0000 || resp_data !== res_val(0)) begin
      n_err++; $display("FAIL idle_done got %b/%b/%h want 0/0000/%h", busy, resp_valid, resp_data, res_val(0));
    end
  endtask

`ifdef DES_ARB_WDOG_EN
  task automatic test_watchdog();
    int cyc;
    req_valid = 4'b0010;
    @(negedge ap_clk);
    req_valid = '0;
    core_ap_ready = 1'b1;
    @(negedge ap_clk);
    core_ap_ready = 1'b0;
    cyc = 1;
    #1;
    while (resp_valid === 4'b0000 && cyc < 100) begin
      @(negedge ap_clk);
      cyc++;
      #1;
    end
    n_vec++;
    if (cyc !== WDOG_N) begin n_err++; $display("FAIL wd_latency got %0d want %0d", cyc, WDOG_N); end
    n_vec++;
    if (resp_valid !== 4'b0010 || resp_err !== 1'b1 || resp_data !== 64'd0) begin
      n_err++; $display("FAIL wd_abort got %b/%b/%h want 0010/1/0", resp_valid, resp_err, resp_data);
    end
    resp_ready = 4'b0010;
    @(negedge ap_clk);
    resp_ready = '0;
    req_valid = 4'b0100;
    @(negedge ap_clk);
    req_valid = '0;
    core_ap_ready = 1'b1;
    @(negedge ap_clk);
    core_ap_ready = 1'b0;
    repeat (WDOG_N - 2) @(negedge ap_clk);
    core_ap_done = 1'b1; core_result = 64'h0BAD_BEEF_0000_0001;
    @(negedge ap_clk);
    core_ap_done = 1'b0; core_result = '0;
    #1;
    n_vec++;
    if (resp_valid !== 4'b0100 || resp_err !== 1'b0 || resp_data !== 64'h0BAD_BEEF_0000_0001) begin
      n_err++; $display("FAIL wd_race got %b/%b/%h want 0100/0/0badbeef00000001", resp_valid, resp_err, resp_data);
    end
    resp_ready = 4'b0100;
    @(negedge ap_clk);
    resp_ready = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    ap_rst = 1'b1; req_valid = '0; resp_ready = '0; req_data = '0;
    core_ap_done = 1'b0; core_ap_ready = 1'b0; core_ap_idle = 1'b1; core_result = '0;
    load_slices();
    test_reset();
    test_single_job();
    test_round_robin();
    test_core_busy();
    test_backpressure();
    test_reset_mid_job();
`ifdef DES_ARB_WDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
